// File: rtl/vec_mul_wide_seq.sv
// rtl/vec_mul_wide_seq.sv - sequential LANES-wide signed element-wise multiplier with optional negate
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; a_vec, b_vec and neg are captured on an IDLE accept
//   neg                   negate every product of this operation
//   a_vec, b_vec          N signed W-bit residues each
//   out_valid / out_ready result handshake; out_vec is held stable while out_valid is high
//   out_vec               N signed WW-bit products

`ifndef N_SLOTS
`define N_SLOTS 8
`endif
`ifndef RNS_PRIME_BITS
`define RNS_PRIME_BITS 16
`endif

module vec_mul_wide_seq #(
    parameter int N     = `N_SLOTS,
    parameter int W     = `RNS_PRIME_BITS,
    parameter int WW    = 2 * W,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   neg,
    input  logic [N-1:0][W-1:0]    a_vec,
    input  logic [N-1:0][W-1:0]    b_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0][WW-1:0]   out_vec
);

    localparam int GROUPS = N / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (N % LANES != 0) begin : g_bad_lanes
        $error("vec_mul_wide_seq: N must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [GW-1:0] grp;
    logic          grp_last;
    logic          neg_q;

    // Operand/result storage viewed as [group][lane]; the packed layout is
    // identical to the flat [slot] view, so slot i = grp*LANES + lane.
    logic [GROUPS-1:0][LANES-1:0][W-1:0]  a_grp, b_grp;
    logic [GROUPS-1:0][LANES-1:0][WW-1:0] out_grp;

    logic signed [WW-1:0] prod [LANES];

    assign grp_last  = (grp == GW'(GROUPS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_vec   = out_grp;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (grp_last)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Only LANES multipliers: the current group's operands are muxed in by grp.
    // Sign-extending to WW first keeps (-2^(W-1))^2 and its negation exact.
    always_comb begin
        logic signed [WW-1:0] a_ext;
        logic signed [WW-1:0] b_ext;
        logic signed [WW-1:0] p;
        a_ext = '0;
        b_ext = '0;
        p     = '0;
        for (int j = 0; j < LANES; j++) begin
            a_ext   = {{(WW-W){a_grp[grp][j][W-1]}}, a_grp[grp][j]};
            b_ext   = {{(WW-W){b_grp[grp][j][W-1]}}, b_grp[grp][j]};
            p       = a_ext * b_ext;
            prod[j] = neg_q ? -p : p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grp     <= '0;
            neg_q   <= 1'b0;
            a_grp   <= '0;
            b_grp   <= '0;
            out_grp <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_grp <= a_vec;
                        b_grp <= b_vec;
                        neg_q <= neg;
                        grp   <= '0;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        out_grp[grp][j] <= prod[j];
                    end
                    grp <= grp_last ? '0 : grp + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mul_wide_seq.sv
// tb/tb_vec_mul_wide_seq.sv - self-checking bench for vec_mul_wide_seq (N=8, LANES=4, W=16)

module tb_vec_mul_wide_seq;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int WW = 32;
    localparam int Q  = 12289;

    typedef logic [N-1:0][W-1:0]  vec_t;
    typedef logic [N-1:0][WW-1:0] wvec_t;

    typedef struct {
        vec_t  a;
        vec_t  b;
        logic  neg;
        wvec_t exp;
    } vec_rec_t;

    typedef struct {
        vec_t  a;
        vec_t  b;
        logic  neg;
        wvec_t exp;
    } sb_ent_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  in_valid = 1'b0;
    logic  in_ready;
    logic  neg = 1'b0;
    vec_t  a_vec = '0;
    vec_t  b_vec = '0;
    logic  out_valid;
    logic  out_ready = 1'b0;
    wvec_t out_vec;

    int passed = 0;
    int total  = 0;
    int n_pop  = 0;
    bit rand_stall = 1'b0;

    sb_ent_t  sb[$];
    vec_rec_t tbl[5];

    vec_mul_wide_seq #(.N(N), .W(W), .WW(WW), .LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .neg       (neg),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic wvec_t model(input vec_t a, input vec_t b, input logic ng);
        wvec_t r;
        for (int i = 0; i < N; i++) begin
            longint p;
            p = longint'($signed(a[i])) * longint'($signed(b[i]));
            if (ng) p = -p;
            r[i] = p[31:0];
        end
        return r;
    endfunction

    function automatic int modq(input int v);
        int r;
        r = v % Q;
        if (r < 0) r += Q;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, 256'(out_valid), 256'(1));
    endtask

    // Scoreboard monitor: samples on the falling edge, so handshakes seen here
    // complete at the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (in_valid && in_ready)
                    sb.push_back('{a_vec, b_vec, neg, model(a_vec, b_vec, neg)});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 256'(0), 256'(1));
                    end else begin
                        sb_ent_t e;
                        logic [255:0] r_dut, r_ref;
                        e = sb.pop_front();
                        n_pop++;
                        check("sb_result", out_vec, e.exp);
                        for (int i = 0; i < N; i++) begin
                            int ra, rb, rr;
                            ra = modq(int'($signed(e.a[i])));
                            rb = modq(int'($signed(e.b[i])));
                            rr = (ra * rb) % Q;
                            if (e.neg) rr = (Q - rr) % Q;
                            r_dut[i*32 +: 32] = 32'(modq($signed(out_vec[i]) % Q));
                            r_ref[i*32 +: 32] = 32'(rr);
                        end
                        check("modq", r_dut, r_ref);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tbl[0].a[i] = 16'(i + 1);   tbl[0].b[i] = 16'hFFFD;
            tbl[0].exp[i] = 32'(-3 * (i + 1));
            tbl[1].a[i] = 16'h8000;     tbl[1].b[i] = 16'h8000;  tbl[1].exp[i] = 32'h4000_0000;
            tbl[2].a[i] = 16'h8000;     tbl[2].b[i] = 16'h8000;  tbl[2].exp[i] = 32'hC000_0000;
            tbl[3].a[i] = 16'h7FFF;     tbl[3].b[i] = 16'h8000;  tbl[3].exp[i] = 32'hC000_8000;
            tbl[4].a[i] = 16'h7FFF;     tbl[4].b[i] = 16'h8000;  tbl[4].exp[i] = 32'h3FFF_8000;
        end
        tbl[0].neg = 1'b0; tbl[1].neg = 1'b0; tbl[2].neg = 1'b1;
        tbl[3].neg = 1'b0; tbl[4].neg = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_vec", out_vec, 256'(0));
        #2 rst_n = 1'b1;
        tick();
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Table vectors: latency, value, return to IDLE
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_vec = tbl[k].a; b_vec = tbl[k].b; neg = tbl[k].neg;
            in_valid = 1'b1;
            tick();                                   // accept edge T
            in_valid = 1'b0;
            tick();                                   // T+1
            check($sformatf("lat_early[%0d]", k), 256'(out_valid), 256'(0));
            tick();                                   // T+2
            check($sformatf("lat[%0d]", k), 256'(out_valid), 256'(1));
            check($sformatf("vec[%0d]", k), out_vec, tbl[k].exp);
            tick();                                   // T+3
            check($sformatf("idle[%0d]", k), 256'({in_ready, out_valid}), 256'(2'b10));
        end

        // Backpressure: held result, new operands ignored until IDLE
        begin
            vec_t  a1, b1, a3, b3;
            wvec_t snap;
            bit    stable;
            for (int i = 0; i < N; i++) begin
                a1[i] = 16'(100 * i - 350); b1[i] = 16'(7 - 5 * i);
                a3[i] = 16'(-1234 + 77 * i); b3[i] = 16'(999 - 301 * i);
            end
            out_ready = 1'b0;
            a_vec = a1; b_vec = b1; neg = 1'b0; in_valid = 1'b1;
            tick();
            a_vec = ~a1; b_vec = ~b1; neg = 1'b1;     // new operands presented during BUSY/DONE
            wait_out("bp_wait1");
            snap = out_vec;
            stable = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (out_vec !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
            end
            check("bp_stable", 256'(stable), 256'(1));
            check("bp_value", snap, model(a1, b1, 1'b0));
            a_vec = a3; b_vec = b3; neg = 1'b1;
            out_ready = 1'b1;
            tick();                                   // DONE -> IDLE
            out_ready = 1'b0;
            check("bp_idle", 256'(in_ready), 256'(1));
            tick();                                   // accept a3/b3
            in_valid = 1'b0;
            wait_out("bp_wait2");
            check("bp_next", out_vec, model(a3, b3, 1'b1));
            out_ready = 1'b1;
            tick();
        end

        // Reset during BUSY
        begin
            bit stale;
            a_vec = tbl[3].a; b_vec = tbl[3].b; neg = 1'b0; in_valid = 1'b1;
            tick();                                   // accept
            in_valid = 1'b0;
            tick();                                   // first BUSY edge done
            #2 rst_n = 1'b0;
            #1;
            check("rstmid_vec", out_vec, 256'(0));
            check("rstmid_valid", 256'(out_valid), 256'(0));
            tick();
            tick();
            #2 rst_n = 1'b1;
            tick();
            check("rstmid_in_ready", 256'(in_ready), 256'(1));
            stale = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (out_valid) stale = 1'b1;
            end
            check("rstmid_no_stale", 256'(stale), 256'(0));
        end

        // Random back-to-back stream with stalls
        begin
            int pop0, n;
            pop0 = n_pop;
            rand_stall = 1'b1;
            for (int k = 0; k < 50; k++) begin
                for (int i = 0; i < N; i++) begin
                    a_vec[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                    b_vec[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                end
                neg = 1'($urandom);
                in_valid = 1'b1;
                n = 0;
                while (!in_ready && n < 100) begin
                    tick();
                    n++;
                end
                if (!in_ready) check("stream_accept_timeout", 256'(0), 256'(1));
                tick();
                in_valid = 1'b0;
            end
            n = 0;
            while ((sb.size() != 0 || !in_ready) && n < 200) begin
                tick();
                n++;
            end
            rand_stall = 1'b0;
            out_ready = 1'b1;
            check("stream_drain", 256'(sb.size()), 256'(0));
            check("stream_count", 256'(n_pop - pop0), 256'(50));
        end

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
